// File: rtl/clmul_pkg.sv
// ----------------------------------------------------------------------------
// clmul_pkg
// Shared definitions for the carry-less multiply-accumulate stage.
//   OPW           : operand / result width (8)
//   frame_state_t : frame state (IDLE = no open frame, ACC = frame open)
//   clmul_lo8()   : behavioural low-half GF(2)[x] product, used as a
//                   reference model
// ----------------------------------------------------------------------------
package clmul_pkg;

  localparam int OPW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } frame_state_t;

  // Shift-and-XOR form: bits shifted past x^7 fall off, which is exactly the
  // low-half truncation.
  function automatic logic [OPW-1:0] clmul_lo8(input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b);
    logic [OPW-1:0] y;
    y = '0;
    for (int i = 0; i < OPW; i++) begin
      if (a[i]) y = y ^ (b << i);
    end
    return y;
  endfunction

endpackage

// File: rtl/clmul_lo8_core.sv
// ----------------------------------------------------------------------------
// clmul_lo8_core
// Purely combinational low-half carry-less multiplier.
//   i_a [7:0] : operand a, bit i = coefficient of x^i
//   i_b [7:0] : operand b
//   o_y [7:0] : y[k] = XOR over i+j=k of a[i]&b[j], k = 0..7
// ----------------------------------------------------------------------------
module clmul_lo8_core
  import clmul_pkg::*;
(
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic [OPW-1:0] o_y
);

  // One partial-product row per output coefficient; only i <= k contributes
  // to the low half, higher terms are left as zero.
  for (genvar gi = 0; gi < OPW; gi++) begin : g_coef
    logic [OPW-1:0] w_row;

    always_comb begin
      w_row = '0;
      for (int j = 0; j <= gi; j++) begin
        w_row[j] = i_a[j] & i_b[gi-j];
      end
    end

    assign o_y[gi] = ^w_row;
  end

endmodule

// File: rtl/clmul_acc_8bit.sv
// ----------------------------------------------------------------------------
// clmul_acc_8bit
// Streaming carry-less multiply-accumulate stage. Registers (a, b) operand
// beats, forms the low-half GF(2)[x] product and XOR-accumulates it across a
// frame; one syndrome per frame is emitted under output backpressure.
//
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand beat valid
//   in_ready   : beat accepted when in_valid && in_ready
//   in_a, in_b : 8-bit operands
//   in_last    : final beat of a frame
//   out_valid  : result register holds an undelivered frame result
//   out_ready  : consumer accepts the result
//   out_data   : XOR of the low-half products of the frame
//   out_count  : terms in the frame, 1..MAX_TERMS
//   out_trunc  : frame was closed by the MAX_TERMS limit rather than in_last
// ----------------------------------------------------------------------------
module clmul_acc_8bit
  import clmul_pkg::*;
#(
  parameter int MAX_TERMS = 16,
  parameter int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_data,
  output logic [CW-1:0]  out_count,
  output logic           out_trunc
);

  // ---------------------------------------------------------------- state
  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic           r_last;
  logic           r_p_valid;

  logic [OPW-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  frame_state_t   r_state;
  frame_state_t   w_state_next;

  logic           r_out_valid;
  logic [OPW-1:0] r_out_data;
  logic [CW-1:0]  r_out_count;
  logic           r_out_trunc;

  // ---------------------------------------------------------------- control
  logic           w_en;
  logic           w_fold;
  logic           w_first;
  logic [OPW-1:0] w_p;
  logic [OPW-1:0] w_acc_next;
  logic [CW-1:0]  w_cnt_next;
  logic           w_close;
  logic           w_load;

  // Whole pipeline stalls only while a finished result is blocked; this
  // gives a combinational out_ready -> in_ready path by design.
  assign w_en     = !(r_out_valid && !out_ready);
  assign in_ready = w_en;

  // A term is folded into the accumulator when stage 1 holds a beat and the
  // pipeline advances.
  assign w_fold  = w_en && r_p_valid;
  assign w_first = (r_state == ST_IDLE);

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_last    <= 1'b0;
      r_p_valid <= 1'b0;
    end else if (w_en) begin
      r_a       <= in_a;
      r_b       <= in_b;
      r_last    <= in_last;
      r_p_valid <= in_valid;
    end
  end

  // ---------------------------------------------------------------- product
  clmul_lo8_core u_core (
    .i_a (r_a),
    .i_b (r_b),
    .o_y (w_p)
  );

  // A new frame starts from zero instead of the stale accumulator contents.
  assign w_acc_next = (w_first ? '0 : r_acc) ^ w_p;
  assign w_cnt_next = (w_first ? '0 : r_cnt) + CW'(1);

  // The MAX_TERMS-th term closes the frame even without in_last; remaining
  // source beats simply open the next frame.
  assign w_close = r_last || (w_cnt_next == CW'(MAX_TERMS));
  assign w_load  = w_fold && w_close;

  // ---------------------------------------------------------------- frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_fold) begin
      w_state_next = w_close ? ST_IDLE : ST_ACC;
    end
  end

  // ---------------------------------------------------------------- stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fold) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------- result
  // Loading a new result takes priority over clearing; a drain and a new
  // close on the same edge keep out_valid high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_trunc <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_next;
      r_out_count <= w_cnt_next;
      r_out_trunc <= !r_last;
    end else if (w_en && r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_clmul_acc_8bit.sv
// ----------------------------------------------------------------------------
// tb_clmul_acc_8bit
// Directed bench for clmul_acc_8bit with MAX_TERMS = 4 so the frame-limit
// close is reachable in a few beats. Delivered results are captured into a
// queue as {data, count, trunc}; each scenario task checks its own results.
// ----------------------------------------------------------------------------
module tb_clmul_acc_8bit;

  localparam int MT = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;

  logic [11:0] res_q[$];

  always #5 clk = ~clk;

  clmul_acc_8bit #(.MAX_TERMS(MT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  // One line per delivered result.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_q.push_back({out_data, out_count, out_trunc});
      n_xfer++;
      $display("[%0t] result data=%02h count=%0d trunc=%0d",
               $time, out_data, out_count, out_trunc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({out_valid, out_data, out_count, out_trunc} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_hold got v=%b d=%02h c=%0d t=%b exp all 0",
               out_valid, out_data, out_count, out_trunc);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_count, out_trunc} !== {1'b1, 13'd0}) begin
      n_err++;
      $display("FAIL reset_release got rdy=%b v=%b d=%02h c=%0d t=%b exp rdy=1 rest 0",
               in_ready, out_valid, out_data, out_count, out_trunc);
    end
  endtask

  task automatic test_single();
    send(8'h03, 8'h03, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency got v=%b exp 0 one cycle after accept", out_valid);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_data, out_count, out_trunc} !== {1'b1, 8'h05, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL single_result got v=%b d=%02h c=%0d t=%b exp v=1 d=05 c=1 t=0",
               out_valid, out_data, out_count, out_trunc);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_two_term();
    send(8'h03, 8'h03, 1'b0);
    send(8'h02, 8'h80, 1'b1);
    tick();
    n_cmp++;
    if ({out_valid, out_data, out_count, out_trunc} !== {1'b1, 8'h05, 3'd2, 1'b0}) begin
      n_err++;
      $display("FAIL two_term got v=%b d=%02h c=%0d t=%b exp v=1 d=05 c=2 t=0",
               out_valid, out_data, out_count, out_trunc);
    end
    send(8'hFF, 8'hFF, 1'b1);
    tick();
    n_cmp++;
    if ({out_valid, out_data, out_count, out_trunc} !== {1'b1, 8'h55, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL ff_square got v=%b d=%02h c=%0d t=%b exp v=1 d=55 c=1 t=0",
               out_valid, out_data, out_count, out_trunc);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int xfer0;
    out_ready = 1'b0;
    // 03*03 = 05, 05*03 = 0F -> 0A over two terms
    send(8'h03, 8'h03, 1'b0);
    send(8'h05, 8'h03, 1'b1);
    tick();
    // Present a further beat that must wait out the stall.
    in_valid = 1'b1; in_a = 8'h07; in_b = 8'h01; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({in_ready, out_valid, out_data, out_count, out_trunc} !==
          {1'b0, 1'b1, 8'h0A, 3'd2, 1'b0}) begin
        n_err++;
        $display("FAIL stall_%0d got rdy=%b v=%b d=%02h c=%0d t=%b exp rdy=0 v=1 d=0a c=2 t=0",
                 i, in_ready, out_valid, out_data, out_count, out_trunc);
      end
      tick();
    end
    xfer0 = n_xfer;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || n_xfer - xfer0 != 1) begin
      n_err++;
      $display("FAIL release_xfer got v=%b xfers=%0d exp v=0 xfers=1",
               out_valid, n_xfer - xfer0);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_data, out_count, out_trunc} !== {1'b1, 8'h07, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL resume got v=%b d=%02h c=%0d t=%b exp v=1 d=07 c=1 t=0",
               out_valid, out_data, out_count, out_trunc);
    end
    tick();
  endtask

  task automatic test_trunc();
    res_q.delete();
    for (int i = 0; i < 6; i++) send(8'h01, 8'h01, (i == 5));
    tick(); tick(); tick();
    n_cmp++;
    if (res_q.size() != 2) begin
      n_err++;
      $display("FAIL trunc_count got %0d results exp 2", res_q.size());
    end else begin
      n_cmp++;
      if (res_q[0] !== {8'h00, 3'd4, 1'b1}) begin
        n_err++;
        $display("FAIL trunc_first got %03h exp %03h", res_q[0], {8'h00, 3'd4, 1'b1});
      end
      n_cmp++;
      if (res_q[1] !== {8'h00, 3'd2, 1'b0}) begin
        n_err++;
        $display("FAIL trunc_second got %03h exp %03h", res_q[1], {8'h00, 3'd2, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va[4];
    logic [7:0]  vb[4];
    logic [11:0] ve[4];
    va = '{8'h03, 8'hFF, 8'h02, 8'h81};
    vb = '{8'h03, 8'hFF, 8'h03, 8'h03};
    // 05, 55, 06, (x^7+1)(x+1) low half = 83
    ve = '{{8'h05, 3'd1, 1'b0}, {8'h55, 3'd1, 1'b0},
           {8'h06, 3'd1, 1'b0}, {8'h83, 3'd1, 1'b0}};
    res_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = va[i]; in_b = vb[i]; in_last = 1'b1;
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_valid_%0d got %b exp 1", i, out_valid);
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_valid_tail got %b exp 1", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || res_q.size() != 4) begin
      n_err++;
      $display("FAIL b2b_end got v=%b results=%0d exp v=0 results=4", out_valid, res_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (res_q[i] !== ve[i]) begin
          n_err++;
          $display("FAIL b2b_result_%0d got %03h exp %03h", i, res_q[i], ve[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    send(8'h03, 8'h03, 1'b0);
    send(8'h05, 8'h03, 1'b0);
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h0F; in_last = 1'b1;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, out_data, out_count, out_trunc} !== 13'd0) begin
      n_err++;
      $display("FAIL midreset_outputs got v=%b d=%02h c=%0d t=%b exp all 0",
               out_valid, out_data, out_count, out_trunc);
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    res_q.delete();
    tick(); tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0 || res_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_dropped got v=%b results=%0d exp v=0 results=0",
               out_valid, res_q.size());
    end
    send(8'h03, 8'h03, 1'b1);
    tick(); tick();
    n_cmp++;
    if (res_q.size() != 1) begin
      n_err++;
      $display("FAIL midreset_after_count got %0d results exp 1", res_q.size());
    end else begin
      n_cmp++;
      if (res_q[0] !== {8'h05, 3'd1, 1'b0}) begin
        n_err++;
        $display("FAIL midreset_after got %03h exp %03h", res_q[0], {8'h05, 3'd1, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_term();
    test_backpressure();
    test_trunc();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
